// File: rtl/bus_responder85.sv
`default_nettype none
// ============================================================================
// bus_responder85 : 8085 multiplexed-bus slave with windowed decode, byte
//                   array storage and programmable READY wait states.
// Revision 1.0
// ============================================================================
module bus_responder85 #(
  parameter int          AW        = 8,
  parameter logic [15:0] ADDR_BASE = 16'h2000,
  parameter logic [15:0] ADDR_MASK = 16'hFF00,
  parameter bit          IO_SPACE  = 1'b0,
  parameter int          WAITCNT   = 0
) (
  input  logic       clk_,
  input  logic       rst_,
  input  logic       ale,
  input  logic       iom_,
  input  logic       rd_,
  input  logic       wr_,
  input  logic [7:0] addh,
  input  logic [7:0] adin,
  output logic [7:0] adout,
  output logic       adoe,
  output logic       ready,
  output logic       sel
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACTIVE = 2'd2
  } state_t;

  localparam int         c_DEPTH    = 1 << AW;
  localparam logic [3:0] c_CNT_LOAD = (WAITCNT > 0) ? 4'(WAITCNT - 1) : 4'd0;

  state_t          r_state, w_state_nx;
  logic [AW-1:0]   r_idx;
  logic            r_ready, w_ready_nx;
  logic            r_sel, w_sel_nx;
  logic            r_adoe, w_adoe_nx;
  logic [7:0]      r_adout, w_adout_nx;
  logic [3:0]      r_cnt, w_cnt_nx;
  logic            r_wr_seen, w_wr_seen_nx;
  logic            r_rd_seen, w_rd_seen_nx;
  logic [7:0]      r_wdata, w_wdata_nx;
  logic [7:0]      r_mem [0:c_DEPTH-1];

  logic [15:0]     w_addr_in;
  logic            w_hit;
  logic            w_take_ale;
  logic            w_mem_we;

  // Decode uses the live bus because the latched copy is only valid next clock.
  assign w_addr_in = {addh, adin};
  assign w_hit     = (iom_ == IO_SPACE) && ((w_addr_in & ADDR_MASK) == ADDR_BASE);

  always_comb begin
    w_state_nx   = r_state;
    w_ready_nx   = r_ready;
    w_sel_nx     = r_sel;
    w_adoe_nx    = r_adoe;
    w_adout_nx   = r_adout;
    w_cnt_nx     = r_cnt;
    w_wr_seen_nx = r_wr_seen;
    w_rd_seen_nx = r_rd_seen;
    w_wdata_nx   = r_wdata;
    w_take_ale   = 1'b0;
    w_mem_we     = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_take_ale = ale;
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_ready_nx = 1'b1;
          w_state_nx = S_ACTIVE;
        end else begin
          w_cnt_nx = r_cnt - 4'd1;
        end
      end
      S_ACTIVE: begin
        if (ale) begin
          // Close (or abort) the current access, then treat ALE as from IDLE.
          w_mem_we   = r_wr_seen;
          w_adoe_nx  = 1'b0;
          w_sel_nx   = 1'b0;
          w_state_nx = S_IDLE;
          w_take_ale = 1'b1;
        end else if (!wr_) begin
          w_wdata_nx   = adin;
          w_wr_seen_nx = 1'b1;
          w_adoe_nx    = 1'b0;
        end else if (!rd_) begin
          w_adout_nx   = r_mem[r_idx];
          w_adoe_nx    = 1'b1;
          w_rd_seen_nx = 1'b1;
        end else if (r_wr_seen) begin
          w_mem_we   = 1'b1;
          w_sel_nx   = 1'b0;
          w_state_nx = S_IDLE;
        end else if (r_rd_seen) begin
          w_adoe_nx  = 1'b0;
          w_sel_nx   = 1'b0;
          w_state_nx = S_IDLE;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase

    if (w_take_ale && w_hit) begin
      w_sel_nx     = 1'b1;
      w_wr_seen_nx = 1'b0;
      w_rd_seen_nx = 1'b0;
      if (WAITCNT == 0) begin
        w_ready_nx = 1'b1;
        w_state_nx = S_ACTIVE;
      end else begin
        w_ready_nx = 1'b0;
        w_cnt_nx   = c_CNT_LOAD;
        w_state_nx = S_WAIT;
      end
    end
  end

  always_ff @(posedge clk_ or posedge rst_) begin
    if (rst_) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_ready   <= 1'b1;
      r_sel     <= 1'b0;
      r_adoe    <= 1'b0;
      r_adout   <= 8'h00;
      r_cnt     <= 4'd0;
      r_wr_seen <= 1'b0;
      r_rd_seen <= 1'b0;
      r_wdata   <= 8'h00;
    end else begin
      r_state   <= w_state_nx;
      r_ready   <= w_ready_nx;
      r_sel     <= w_sel_nx;
      r_adoe    <= w_adoe_nx;
      r_adout   <= w_adout_nx;
      r_cnt     <= w_cnt_nx;
      r_wr_seen <= w_wr_seen_nx;
      r_rd_seen <= w_rd_seen_nx;
      r_wdata   <= w_wdata_nx;
      if (ale) begin
        r_idx <= w_addr_in[AW-1:0];
      end
    end
  end

  // Commit uses the index of the access being closed, before any new ALE lands.
  always_ff @(posedge clk_) begin
    if (w_mem_we) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

  assign adout = r_adout;
  assign adoe  = r_adoe;
  assign ready = r_ready;
  assign sel   = r_sel;

endmodule
`default_nettype wire

// File: tb/tb_bus_responder85.sv
`default_nettype none
// Testbench for bus_responder85: default, I/O-space and two-wait-state instances
// share one bus; each scenario checks the instance it targets.
module tb_bus_responder85;

  logic       clk_ = 1'b0;
  logic       rst_ = 1'b1;
  logic       ale  = 1'b0;
  logic       iom_ = 1'b0;
  logic       rd_  = 1'b1;
  logic       wr_  = 1'b1;
  logic [7:0] addh = 8'h00;
  logic [7:0] adin = 8'h00;

  logic [7:0] d_adout, i_adout, w_adout;
  logic       d_adoe, i_adoe, w_adoe;
  logic       d_ready, i_ready, w_ready;
  logic       d_sel, i_sel, w_sel;

  int n_cmp = 0;
  int n_bad = 0;

  bus_responder85 u_dut (
    .clk_(clk_), .rst_(rst_), .ale(ale), .iom_(iom_), .rd_(rd_), .wr_(wr_),
    .addh(addh), .adin(adin), .adout(d_adout), .adoe(d_adoe), .ready(d_ready), .sel(d_sel)
  );

  bus_responder85 #(.IO_SPACE(1'b1)) u_io (
    .clk_(clk_), .rst_(rst_), .ale(ale), .iom_(iom_), .rd_(rd_), .wr_(wr_),
    .addh(addh), .adin(adin), .adout(i_adout), .adoe(i_adoe), .ready(i_ready), .sel(i_sel)
  );

  bus_responder85 #(.WAITCNT(2)) u_ws (
    .clk_(clk_), .rst_(rst_), .ale(ale), .iom_(iom_), .rd_(rd_), .wr_(wr_),
    .addh(addh), .adin(adin), .adout(w_adout), .adoe(w_adoe), .ready(w_ready), .sel(w_sel)
  );

  always #5 clk_ = ~clk_;

  task automatic tick;
    @(posedge clk_);
    #1;
  endtask

  task automatic put_ale(input logic [15:0] a, input logic io);
    ale  = 1'b1;
    addh = a[15:8];
    adin = a[7:0];
    iom_ = io;
    tick();
    ale  = 1'b0;
  endtask

  // Full write cycle with nw clocks allowed for wait states before the strobe.
  task automatic do_write(input logic [15:0] a, input logic [7:0] d, input logic io, input int nw);
    put_ale(a, io);
    repeat (nw) tick();
    wr_  = 1'b0;
    adin = d;
    tick();
    tick();
    wr_ = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    rst_ = 1'b1;
    ale  = 1'($urandom);
    iom_ = 1'($urandom);
    rd_  = 1'($urandom);
    wr_  = 1'($urandom);
    addh = 8'($urandom);
    adin = 8'($urandom);
    repeat (3) tick();
    n_cmp++;
    if ({d_ready, d_adoe, d_adout, d_sel} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_outputs: got ready=%b adoe=%b adout=%h sel=%b, want 1 0 00 0",
               d_ready, d_adoe, d_adout, d_sel);
    end
    n_cmp++;
    if ({w_ready, w_adoe, w_sel} !== 3'b100) begin
      n_bad++;
      $display("FAIL reset_ws: got ready=%b adoe=%b sel=%b, want 1 0 0", w_ready, w_adoe, w_sel);
    end
    ale = 1'b0; rd_ = 1'b1; wr_ = 1'b1; iom_ = 1'b0;
    rst_ = 1'b0;
    tick();
    put_ale(16'h3000, 1'b0);
    tick();
    n_cmp++;
    if ({d_ready, d_adoe, d_adout, d_sel} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
      n_bad++;
      $display("FAIL ale_miss_3000: got ready=%b adoe=%b adout=%h sel=%b, want 1 0 00 0",
               d_ready, d_adoe, d_adout, d_sel);
    end
  endtask

  task automatic test_write_read;
    put_ale(16'h2034, 1'b0);
    n_cmp++;
    if ({d_sel, d_ready} !== 2'b11) begin
      n_bad++;
      $display("FAIL wr_select: got sel=%b ready=%b, want 1 1", d_sel, d_ready);
    end
    wr_ = 1'b0; adin = 8'hA5;
    tick(); tick();
    wr_ = 1'b1;
    tick();
    n_cmp++;
    if (d_sel !== 1'b0) begin
      n_bad++;
      $display("FAIL wr_close_sel: got %b want 0", d_sel);
    end
    put_ale(16'h2034, 1'b0);
    rd_ = 1'b0;
    n_cmp++;
    if (d_adoe !== 1'b0) begin
      n_bad++;
      $display("FAIL rd_early_adoe: got %b want 0", d_adoe);
    end
    tick();
    n_cmp++;
    if ({d_adoe, d_adout} !== {1'b1, 8'hA5}) begin
      n_bad++;
      $display("FAIL rd_data: got adoe=%b adout=%h, want 1 a5", d_adoe, d_adout);
    end
    tick();
    rd_ = 1'b1;
    tick();
    n_cmp++;
    if ({d_adoe, d_sel} !== 2'b00) begin
      n_bad++;
      $display("FAIL rd_release: got adoe=%b sel=%b, want 0 0", d_adoe, d_sel);
    end
  endtask

  task automatic test_decode_miss;
    put_ale(16'h3034, 1'b0);
    rd_ = 1'b0;
    tick(); tick();
    n_cmp++;
    if ({d_adoe, d_ready, d_sel} !== 3'b010) begin
      n_bad++;
      $display("FAIL miss_addr: got adoe=%b ready=%b sel=%b, want 0 1 0", d_adoe, d_ready, d_sel);
    end
    rd_ = 1'b1;
    tick();
    put_ale(16'h2034, 1'b0);
    rd_ = 1'b0;
    tick(); tick();
    n_cmp++;
    if ({i_adoe, i_ready, i_sel} !== 3'b010) begin
      n_bad++;
      $display("FAIL miss_space: got adoe=%b ready=%b sel=%b, want 0 1 0", i_adoe, i_ready, i_sel);
    end
    rd_ = 1'b1;
    tick();
    // Device cycle: only the I/O-space instance answers.
    do_write(16'h2034, 8'h3C, 1'b1, 0);
    put_ale(16'h2034, 1'b1);
    n_cmp++;
    if ({i_sel, d_sel} !== 2'b10) begin
      n_bad++;
      $display("FAIL io_select: got io_sel=%b mem_sel=%b, want 1 0", i_sel, d_sel);
    end
    rd_ = 1'b0;
    tick();
    n_cmp++;
    if ({i_adoe, i_adout} !== {1'b1, 8'h3C}) begin
      n_bad++;
      $display("FAIL io_read: got adoe=%b adout=%h, want 1 3c", i_adoe, i_adout);
    end
    rd_ = 1'b1;
    tick();
    iom_ = 1'b0;
  endtask

  task automatic test_wait_states;
    do_write(16'h2010, 8'h77, 1'b0, 2);
    put_ale(16'h2010, 1'b0);
    rd_ = 1'b0;
    n_cmp++;
    if (w_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL ws_ready_t1: got %b want 0", w_ready);
    end
    tick();
    n_cmp++;
    if ({w_ready, w_adoe} !== 2'b00) begin
      n_bad++;
      $display("FAIL ws_ready_t2: got ready=%b adoe=%b, want 0 0", w_ready, w_adoe);
    end
    tick();
    n_cmp++;
    if ({w_ready, w_adoe} !== 2'b10) begin
      n_bad++;
      $display("FAIL ws_ready_back: got ready=%b adoe=%b, want 1 0", w_ready, w_adoe);
    end
    tick();
    n_cmp++;
    if ({w_adoe, w_adout} !== {1'b1, 8'h77}) begin
      n_bad++;
      $display("FAIL ws_read_data: got adoe=%b adout=%h, want 1 77", w_adoe, w_adout);
    end
    rd_ = 1'b1;
    tick();
    n_cmp++;
    if ({w_adoe, w_sel} !== 2'b00) begin
      n_bad++;
      $display("FAIL ws_release: got adoe=%b sel=%b, want 0 0", w_adoe, w_sel);
    end
  endtask

  task automatic test_back_to_back;
    put_ale(16'h2001, 1'b0);
    wr_ = 1'b0; adin = 8'h5A;
    tick(); tick();
    wr_ = 1'b1; ale = 1'b1; addh = 8'h20; adin = 8'h01; iom_ = 1'b0;
    tick();
    ale = 1'b0;
    n_cmp++;
    if ({d_sel, d_ready, d_adoe} !== 3'b110) begin
      n_bad++;
      $display("FAIL b2b_select: got sel=%b ready=%b adoe=%b, want 1 1 0", d_sel, d_ready, d_adoe);
    end
    rd_ = 1'b0;
    tick();
    n_cmp++;
    if ({d_adoe, d_adout} !== {1'b1, 8'h5A}) begin
      n_bad++;
      $display("FAIL b2b_read: got adoe=%b adout=%h, want 1 5a", d_adoe, d_adout);
    end
    rd_ = 1'b1;
    tick();
  endtask

  task automatic test_abort;
    put_ale(16'h2034, 1'b0);
    adin = 8'hEE;
    tick();
    put_ale(16'h3034, 1'b0);
    n_cmp++;
    if ({d_sel, d_adoe} !== 2'b00) begin
      n_bad++;
      $display("FAIL abort_close: got sel=%b adoe=%b, want 0 0", d_sel, d_adoe);
    end
    put_ale(16'h2034, 1'b0);
    rd_ = 1'b0;
    tick();
    n_cmp++;
    if ({d_adoe, d_adout} !== {1'b1, 8'hA5}) begin
      n_bad++;
      $display("FAIL abort_no_write: got adoe=%b adout=%h, want 1 a5", d_adoe, d_adout);
    end
    rd_ = 1'b1;
    tick();
  endtask

  task automatic test_reset_in_wait;
    put_ale(16'h2010, 1'b0);
    wr_ = 1'b0; adin = 8'h99;
    tick();
    n_cmp++;
    if (w_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL rw_in_wait: got ready=%b want 0", w_ready);
    end
    rst_ = 1'b1;
    #1;
    n_cmp++;
    if ({w_ready, w_adoe, w_sel} !== 3'b100) begin
      n_bad++;
      $display("FAIL rw_async: got ready=%b adoe=%b sel=%b, want 1 0 0", w_ready, w_adoe, w_sel);
    end
    tick(); tick();
    wr_ = 1'b1;
    tick();
    rst_ = 1'b0;
    tick();
    put_ale(16'h2010, 1'b0);
    rd_ = 1'b0;
    tick(); tick(); tick();
    n_cmp++;
    if ({w_adoe, w_adout} !== {1'b1, 8'h77}) begin
      n_bad++;
      $display("FAIL rw_byte_kept: got adoe=%b adout=%h, want 1 77", w_adoe, w_adout);
    end
    rd_ = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_decode_miss();
    test_wait_states();
    test_back_to_back();
    test_abort();
    test_reset_in_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bus_responder85.md
Name: bus_responder85

Overview:
- Slave-side responder for the 8085-style multiplexed bus that the core's control unit drives.
- Decodes ALE, IO/M_, RD_ and WR_, latches the multiplexed low address and checks a base/mask window.
- Serves reads and writes from an internal byte array and inserts a programmable number of wait states through READY.
- Used as on-chip RAM or as an I/O port bank in system benches and top-level integration.

Parameters:
- AW, 8: log2 of internal byte array size; array index = addr[AW-1:0].
- ADDR_BASE, 16'h2000: 16-bit address of the window base.
- ADDR_MASK, 16'hFF00: bits compared for select. A hit requires (addr & ADDR_MASK) == ADDR_BASE.
- IO_SPACE, 0: 0 responds only to memory cycles (iom_=0); 1 responds only to device cycles (iom_=1).
- WAITCNT, 0: wait states requested per access, range 0..15.

Ports:
- clk_ input 1: clock; all sampling on posedge.
- rst_ input 1: reset, asynchronous, active-high.
- ale input 1: address latch enable, high during T1.
- iom_ input 1: IO/M_ status.
- rd_ input 1: read strobe, active-low.
- wr_ input 1: write strobe, active-low.
- addh input 8: upper address bus.
- adin input 8: multiplexed AD bus, input side.
- adout output 8: read data toward the AD bus.
- adoe output 1: AD bus drive enable; the top level builds the tristate from adoe.
- ready output 1: READY to the CPU.
- sel output 1: high while a selected access is in progress.

Behaviour:
- Reset (async, any state): state=IDLE, adout=8'h00, adoe=0, ready=1, sel=0, cnt=0, wr_seen=0. Array contents are not reset.
- Latched address: addr={addh,adin}, captured on any posedge with ale=1.
- Hit: (iom_==IO_SPACE) && ((addr & ADDR_MASK)==ADDR_BASE).
- FSM states: IDLE, WAIT, ACTIVE.
- IDLE:
  - ale=1 and hit: sel<=1 and wr_seen<=0.
  - If WAITCNT==0: ready<=1, go to ACTIVE.
  - Else: ready<=0, cnt<=WAITCNT-1, go to WAIT.
  - ale=1 with no hit: stay in IDLE, outputs unchanged.
- WAIT:
  - ready=0. cnt decrements each clock.
  - At cnt==0: ready<=1, go to ACTIVE.
  - Strobes are ignored in WAIT, and adoe stays 0.
  - Net effect: ready reads low for exactly WAITCNT clocks starting the clock after ALE, giving the CPU WAITCNT Tw states.
- ACTIVE, read:
  - Each clock with rd_=0: adout<=mem[addr[AW-1:0]] and adoe<=1.
  - Clock with rd_=1 after rd_ was low: adoe<=0, go to IDLE, sel<=0.
  - Latency: adoe/adout valid one clock after rd_ is first sampled low (T3 with no waits).
- ACTIVE, write:
  - Each clock with wr_=0: wdata<=adin and wr_seen<=1.
  - First clock with wr_=1 and wr_seen=1: mem[addr]<=wdata (the last sampled byte), go to IDLE, sel<=0.
- Simultaneous strobe release and ale=1 (T3 to T1 back-to-back):
  - The commit/close completes first.
  - The new ALE is processed in the same clock exactly as from IDLE, so no cycle is lost.
  - A read of the just-written address in that next cycle returns the new data.
- ale=1 in ACTIVE with no strobe ever seen (e.g. INTA, bus idle, halt cycles): abort with no commit and no drive, then process the ALE as from IDLE.
- rd_ and wr_ both low: error case. Write has priority, adoe forced 0.
- adoe is never high outside ACTIVE.
- rst_ mid-access: any pending write is discarded and the bus is released in the same instant.
- Counter widths: cnt is 4 bits; WAITCNT values above 15 are illegal.

Test Plan:
- Reset check: assert rst_ with random inputs -> ready=1, adoe=0, adout=00, sel=0. Drop rst_; an ale pulse at addr 3000 -> nothing changes.
- Write then read at defaults (addr 2034, data A5):
  - Write cycle (ALE, then wr_ low for 2 clocks) -> mem[34]=A5 committed at the wr_ rising edge.
  - Read cycle -> adoe=1 and adout=A5 exactly on the clock after rd_ is sampled low; adoe=0 the clock after rd_ rises.
- Decode misses: read at 3034 -> adoe stays 0, ready stays 1, sel=0. Same with IO_SPACE=1 and a memory cycle to 2034 -> ignored.
- WAITCNT=2, read at 2010 -> ready low for exactly 2 clocks after ALE, then high; adoe asserts only after ready returns high; data correct.
- Back-to-back: write 5A to 2001 with wr_ rising on the same edge as the next ale=1, which is a read of 2001 -> read returns 5A with no dropped cycle.
- Abort and reset:
  - ALE hit followed by a second ALE with no strobe -> no write, no drive.
  - rst_ pulsed while in WAIT during a write -> ready=1 and adoe=0 immediately; array byte unchanged.
